// File: rtl/three_way_mux_arbiter.sv
// Round-robin arbiter for three requesters driving a registered 3:1 mux.
// Ownership is bounded by MAX_HOLD cycles whenever another requester is waiting.
module three_way_mux_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [2:0] din,
   output logic [2:0] gnt,
   output logic       sel1,
   output logic       sel2,
   output logic       busy,
   output logic       dout
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state, state_nxt;
   logic [1:0] owner, owner_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic [2:0] gnt_nxt;
   logic       sel1_nxt, sel2_nxt, dout_nxt;
   logic [2:0] others;

   // owner doubles as last_owner: it only changes on a new grant
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] cand);
      logic [1:0] first, second, third;
      case (last)
         2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
         2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
         default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
      endcase
      if (cand[first])       rr_pick = first;
      else if (cand[second]) rr_pick = second;
      else                   rr_pick = third;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      onehot = 3'b001 << idx;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 2'd2;
         hold_cnt <= '0;
         gnt      <= '0;
         sel1     <= 1'b0;
         sel2     <= 1'b0;
         dout     <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         hold_cnt <= hold_cnt_nxt;
         gnt      <= gnt_nxt;
         sel1     <= sel1_nxt;
         sel2     <= sel2_nxt;
         dout     <= dout_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      hold_cnt_nxt = hold_cnt;
      others       = req & ~onehot(owner);
      case (state)
         IDLE: begin
            if (req != 3'b000) begin
               state_nxt    = HOLD;
               owner_nxt    = rr_pick(owner, req);
               hold_cnt_nxt = '0;
            end
         end
         HOLD: begin
            if (!req[owner]) begin
               hold_cnt_nxt = '0;
               if (others != 3'b000) owner_nxt = rr_pick(owner, others);
               else                  state_nxt = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               // timeout with nobody else waiting re-grants the same owner
               hold_cnt_nxt = '0;
               if (others != 3'b000) owner_nxt = rr_pick(owner, others);
            end else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      gnt_nxt  = (state_nxt == HOLD) ? onehot(owner_nxt) : 3'b000;
      sel1_nxt = (state_nxt == HOLD) && (owner_nxt == 2'd2);
      sel2_nxt = (state_nxt == HOLD) && (owner_nxt == 2'd1);
      dout_nxt = (state == HOLD) ? din[owner] : 1'b0;
   end

   assign busy = (state == HOLD);

endmodule

// File: tb/tb_three_way_mux_arbiter.sv
// Bench for three_way_mux_arbiter: directed scenarios plus random traffic
// compared against a round-robin ownership model kept in plain integers.
module tb_three_way_mux_arbiter;

   localparam int MH = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req, din;
   logic [2:0] gnt;
   logic       sel1, sel2, busy, dout;

   int total = 0;
   int bad   = 0;

   // model: owner -1 means nobody holds the mux
   int         m_owner, m_cnt, m_last;
   logic       m_dout;
   logic [2:0] s_req;

   always #5 clk = ~clk;

   three_way_mux_arbiter #(.MAX_HOLD(MH)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .din  (din),
      .gnt  (gnt),
      .sel1 (sel1),
      .sel2 (sel2),
      .busy (busy),
      .dout (dout)
   );

   function automatic int pick(int last, logic [2:0] r, int excl);
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (last + k) % 3;
         if (c != excl && ((r >> c) & 3'b001) != 3'b000) return c;
      end
      return -1;
   endfunction

   function automatic logic [2:0] exp_gnt();
      if (m_owner < 0) return 3'b000;
      return 3'b001 << m_owner;
   endfunction

   function automatic logic [1:0] exp_sel();
      return {m_owner == 2, m_owner == 1};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 2;
      m_dout  = 1'b0;
   endtask

   // advance one rising edge, update the model from the sampled inputs
   task automatic tick();
      int w;
      @(posedge clk);
      s_req  = req;
      m_dout = (m_owner >= 0) ? ((din >> m_owner) & 3'b001) != 3'b000 : 1'b0;
      if (m_owner < 0) begin
         if (s_req != 3'b000) begin
            m_owner = pick(m_last, s_req, -1);
            m_last  = m_owner;
            m_cnt   = 0;
         end
      end else if (((s_req >> m_owner) & 3'b001) == 3'b000) begin
         w     = pick(m_last, s_req, m_owner);
         m_cnt = 0;
         m_owner = w;
         if (w >= 0) m_last = w;
      end else if (m_cnt == MH - 1) begin
         w     = pick(m_last, s_req, m_owner);
         m_cnt = 0;
         if (w >= 0) begin
            m_owner = w;
            m_last  = w;
         end
      end else begin
         m_cnt++;
      end
      #1;
   endtask

   task automatic drive(input logic [2:0] r, input logic [2:0] d);
      @(negedge clk);
      req = r;
      din = d;
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 3'b000;
      din   = 3'b000;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 3'b111;
      din   = 3'b111;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt: got %b want 000", gnt); end
      total++; if ({sel1, sel2} !== 2'b00) begin bad++; $display("FAIL rst_sel: got %b want 00", {sel1, sel2}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (dout !== 1'b0) begin bad++; $display("FAIL rst_dout: got %b want 0", dout); end
      @(negedge clk);
      rst_n = 1'b1;
      req   = 3'b000;
      for (int i = 0; i < 2; i++) begin
         drive(3'b000, 3'b111);
         total++; if (gnt !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_req[%0d]: got gnt=%b busy=%b want 000/0", i, gnt, busy); end
      end
   endtask

   task automatic test_rotation();
      logic [2:0] tbl_g [6];
      logic [1:0] tbl_s [6];
      tbl_g = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
      tbl_s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(3'b111, 3'($urandom_range(0, 7)));
         total++; if (gnt !== tbl_g[i % 6]) begin bad++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, tbl_g[i % 6]); end
         total++; if ({sel1, sel2} !== tbl_s[i % 6]) begin bad++; $display("FAIL rot_sel[%0d]: got %b want %b", i, {sel1, sel2}, tbl_s[i % 6]); end
         total++; if (dout !== m_dout) begin bad++; $display("FAIL rot_dout[%0d]: got %b want %b", i, dout, m_dout); end
      end
   endtask

   task automatic test_release();
      logic [2:0] want_g [5];
      logic       want_d [5];
      want_g = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
      want_d = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive((i < 3) ? 3'b010 : 3'b000, 3'b010);
         total++; if (gnt !== want_g[i]) begin bad++; $display("FAIL rel_gnt[%0d]: got %b want %b", i, gnt, want_g[i]); end
         total++; if (dout !== want_d[i]) begin bad++; $display("FAIL rel_dout[%0d]: got %b want %b", i, dout, want_d[i]); end
         total++; if (busy !== (want_g[i] != 3'b000)) begin bad++; $display("FAIL rel_busy[%0d]: got %b want %b", i, busy, want_g[i] != 3'b000); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(3'b001, 3'b000);
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL b2b_first: got %b want 001", gnt); end
      drive(3'b110, 3'b000);
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL b2b_handoff: got %b want 010", gnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
   endtask

   task automatic test_single_c();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(3'b100, 3'b100);
         total++; if (gnt !== 3'b100 || {sel1, sel2} !== 2'b10) begin bad++; $display("FAIL only_c[%0d]: got gnt=%b sel=%b want 100/10", i, gnt, {sel1, sel2}); end
         if (i > 0) begin
            total++; if (dout !== 1'b1) begin bad++; $display("FAIL only_c_dout[%0d]: got %b want 1", i, dout); end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(3'b010, 3'b010);
      drive(3'b010, 3'b010);
      total++; if (gnt !== 3'b010 || dout !== 1'b1) begin bad++; $display("FAIL ar_pre: got gnt=%b dout=%b want 010/1", gnt, dout); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL ar_gnt: got %b want 000", gnt); end
      total++; if ({sel1, sel2} !== 2'b00 || busy !== 1'b0 || dout !== 1'b0) begin bad++; $display("FAIL ar_outs: got sel=%b busy=%b dout=%b want 00/0/0", {sel1, sel2}, busy, dout); end
      @(negedge clk);
      rst_n = 1'b1;
      req   = 3'b111;
      tick();
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL ar_after: got %b want 001", gnt); end
   endtask

   task automatic test_random();
      logic [2:0] r;
      do_reset();
      r = 3'b000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
         drive(r, 3'($urandom_range(0, 7)));
         total++; if (gnt !== exp_gnt()) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, gnt, exp_gnt()); end
         total++; if ({sel1, sel2} !== exp_sel()) begin bad++; $display("FAIL rnd_sel[%0d]: got %b want %b", i, {sel1, sel2}, exp_sel()); end
         total++; if (busy !== (m_owner >= 0)) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_owner >= 0); end
         total++; if (dout !== m_dout) begin bad++; $display("FAIL rnd_dout[%0d]: got %b want %b", i, dout, m_dout); end
         total++; if ((gnt & (gnt - 3'b001)) !== 3'b000 || {sel1, sel2} === 2'b11) begin bad++; $display("FAIL rnd_onehot[%0d]: got gnt=%b sel=%b want onehot/not 11", i, gnt, {sel1, sel2}); end
         total++; if ((gnt & ~s_req) !== 3'b000) begin bad++; $display("FAIL rnd_req_low[%0d]: got gnt=%b req=%b want gnt within req", i, gnt, s_req); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b000;
      din   = 3'b000;
      model_reset();
      test_reset();
      test_rotation();
      test_release();
      test_back_to_back();
      test_single_c();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/three_way_mux_arbiter.md
THREE_WAY_MUX_ARBITER -- requirements
Module: three_way_mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive cycles one requester may own the 3:1 mux; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  request vector; bit0=A, bit1=B, bit2=C; level-sensitive, held high while access is wanted.
REQ-005 din  input  3  data bits; bit0=A, bit1=B, bit2=C; routed through the mux.
REQ-006 gnt  output  3  registered grant; one-hot or all-zero.
REQ-007 sel1  output  1  registered mux select, high bit.
REQ-008 sel2  output  1  registered mux select, low bit.
REQ-009 busy  output  1  high while any grant is active.
REQ-010 dout  output  1  registered muxed data bit.

Function
REQ-011 Two states SHALL exist: IDLE (no owner) and HOLD (one owner).
REQ-012 Select encoding SHALL be: owner A -> {sel1,sel2}=00; B -> 01; C -> 10; IDLE -> 00; 11 SHALL never be driven.
REQ-013 IDLE: on an edge with req!=0, the block SHALL enter HOLD, assert gnt for the round-robin winner and set hold_cnt=0; grant latency is 1 cycle from req sampled high.
REQ-014 Round-robin SHALL search A->B->C->A starting at the requester after last_owner; last_owner updates on every new grant.
REQ-015 HOLD: while req[owner]=1 and hold_cnt<MAX_HOLD-1, gnt, sel1 and sel2 SHALL be held and hold_cnt SHALL increment each cycle.
REQ-016 Release: on an edge where req[owner]=0, if any other req is high, ownership SHALL pass directly to the next round-robin winner at that edge (no idle cycle); otherwise the block SHALL return to IDLE with gnt=000.
REQ-017 Timeout: on an edge where req[owner]=1 and hold_cnt=MAX_HOLD-1, ownership SHALL pass to the next round-robin winner among the other requesters; if no other requester is high, the same owner SHALL be re-granted with hold_cnt=0.
REQ-018 A requester SHALL therefore own the mux for at most MAX_HOLD consecutive cycles while others wait; MAX_HOLD=1 rotates every cycle.
REQ-019 Simultaneous release and new requests SHALL resolve by round-robin at that same edge; the releasing owner is excluded.
REQ-020 dout SHALL equal the din bit of the owner, sampled on the edge after gnt was asserted, or 0 when gnt=000 (1-cycle data latency).
REQ-021 busy SHALL be 1 in HOLD and 0 in IDLE.
REQ-022 gnt SHALL never have more than one bit set, and SHALL never be asserted to a requester whose req was low at the granting edge.

Reset
REQ-023 While rst_n=0: state=IDLE; gnt=000; sel1=0; sel2=0; busy=0; dout=0; hold_cnt=0; last_owner=C, so A wins the first arbitration.
REQ-024 Reset assertion mid-grant SHALL clear all outputs immediately (asynchronously), without waiting for a clock edge.
REQ-025 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with req!=0.

Verification
REQ-026 Reset, then req=111 held, MAX_HOLD=2 -> gnt sequence 001,001,010,010,100,100,001...; sel pairs 00,00,01,01,10,10,00.
REQ-027 req=010 for 3 cycles then 000, din=010 -> gnt=010 for 3 cycles, then 000; dout=1 starting 1 cycle after gnt; busy falls with gnt.
REQ-028 Owner A drops req on the same edge B and C rise, last_owner=A -> gnt goes 001->010 directly, with no 000 cycle.
REQ-029 Only C requesting continuously, MAX_HOLD=4 -> gnt=100 held indefinitely; hold_cnt wraps 0..3 and re-grants C.
REQ-030 rst_n pulled low mid-HOLD with gnt=010 -> gnt=000, sel=00 and dout=0 before the next edge; after release with req=111 -> gnt=001.
REQ-031 Every cycle of every test: gnt one-hot or zero, {sel1,sel2}!=11, and gnt bit set only if the matching req was high at the granting edge.
